// File: rtl/axi_wr_slave.sv
// Single-beat AXI-style write slave: captures AW and W (in either order),
// validates size/alignment/last, drives one strobed 64-bit memory write with a
// bounded wait on mem_ready, then returns a B response.
module axi_wr_slave #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic [63:0]       WDATA,
   input  logic              WLAST,
   input  logic [3:0]        WUSER,
   output logic              BVALID,
   input  logic              BREADY,
   output logic [1:0]        BRESP,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wstrb,
   input  logic              mem_ready
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_W,
      WAIT_AW,
      MEM,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]       mem_wdata_q, mem_wdata_d;
   logic [7:0]        mem_wstrb_q, mem_wstrb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [3:0]        wuser_q, wuser_d;
   logic              wlast_q, wlast_d;

   logic              aw_hs, w_hs;
   logic [ADDR_W-1:0] eff_addr;
   logic [63:0]       eff_wdata;
   logic [3:0]        eff_wuser;
   logic              eff_wlast;
   logic [7:0]        size_mask;
   logic              size_ok, align_ok, txn_err;
   logic [7:0]        lane_strb;
   logic [63:0]       lane_data;

   // Operands of the completing transaction: the half arriving this cycle
   // comes from the ports, the half captured earlier from its register.
   always_comb begin
      aw_hs     = AWVALID && awready_q;
      w_hs      = WVALID && wready_q;
      eff_addr  = aw_hs ? AWADDR : addr_q;
      eff_wdata = w_hs ? WDATA : wdata_q;
      eff_wuser = w_hs ? WUSER : wuser_q;
      eff_wlast = w_hs ? WLAST : wlast_q;
      size_mask = 8'h00;
      size_ok   = 1'b1;
      align_ok  = 1'b1;
      case (eff_wuser)
         4'b0001: size_mask = 8'h01;
         4'b0010: begin size_mask = 8'h03; align_ok = (eff_addr[0] == 1'b0);   end
         4'b0100: begin size_mask = 8'h0F; align_ok = (eff_addr[1:0] == 2'b00); end
         4'b1000: begin size_mask = 8'hFF; align_ok = (eff_addr[2:0] == 3'b000); end
         default: size_ok = 1'b0;
      endcase
      txn_err   = !size_ok || !align_ok || !eff_wlast;
      lane_strb = size_mask << eff_addr[2:0];
      lane_data = eff_wdata << {eff_addr[2:0], 3'b000};
   end

   // Next-state logic; all outputs are decoded from the next state so they
   // leave the flops without any combinational path from the inputs.
   always_comb begin
      logic both_done;
      state_d     = state_q;
      bresp_d     = bresp_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wuser_d     = wuser_q;
      wlast_d     = wlast_q;
      both_done   = 1'b0;

      if (aw_hs) addr_d = AWADDR;
      if (w_hs) begin
         wdata_d = WDATA;
         wuser_d = WUSER;
         wlast_d = WLAST;
      end

      case (state_q)
         IDLE: begin
            if (aw_hs && w_hs) both_done = 1'b1;
            else if (aw_hs)    state_d   = WAIT_W;
            else if (w_hs)     state_d   = WAIT_AW;
         end
         WAIT_W:  if (w_hs)  both_done = 1'b1;
         WAIT_AW: if (aw_hs) both_done = 1'b1;
         MEM: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_ready) begin
               state_d = RESP;
               bresp_d = RESP_OKAY;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               bresp_d = RESP_SLVERR;
            end
         end
         RESP: if (BREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (both_done) begin
         if (txn_err) begin
            state_d = RESP;
            bresp_d = RESP_SLVERR;
         end else begin
            state_d     = MEM;
            cnt_d       = '0;
            mem_addr_d  = {eff_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_d = lane_data;
            mem_wstrb_d = lane_strb;
         end
      end

      awready_d = (state_d == IDLE) || (state_d == WAIT_AW);
      wready_d  = (state_d == IDLE) || (state_d == WAIT_W);
      bvalid_d  = (state_d == RESP);
      mem_we_d  = (state_d == MEM);
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wuser_q     <= '0;
         wlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wuser_q     <= wuser_d;
         wlast_q     <= wlast_d;
      end
   end

   assign AWREADY   = awready_q;
   assign WREADY    = wready_q;
   assign BVALID    = bvalid_q;
   assign BRESP     = bresp_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Testbench for axi_wr_slave: directed cases plus randomized transactions,
// each compared against a transaction-level reference model.
module tb_axi_wr_slave;

   localparam int TIMEOUT = 16;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        AWVALID, AWREADY;
   logic [31:0] AWADDR;
   logic        WVALID, WREADY;
   logic [63:0] WDATA;
   logic        WLAST;
   logic [3:0]  WUSER;
   logic        BVALID, BREADY;
   logic [1:0]  BRESP;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 ACLK = ~ACLK;

   axi_wr_slave #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST), .WUSER(WUSER),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int size_of(input logic [3:0] u);
      case (u)
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0100: return 4;
         4'b1000: return 8;
         default: return 0;
      endcase
   endfunction

   // One full transaction: AW/W with independent delays, mem_ready after rd
   // MEM cycles, BREADY held low for bd cycles (optionally with a new AW/W
   // waiting), then the B handshake.
   task automatic do_txn(input logic [31:0] addr, input logic [3:0] user,
                         input logic [63:0] data, input logic last,
                         input int aw_del, input int w_del, input int rd,
                         input int bd, input bit stall_next);
      int          sz, off, cyc, we_cnt, held_bad, stall_bad, e_we;
      bit          err, aw_done, w_done, ar, wr;
      logic [7:0]  e_strb;
      logic [63:0] e_data, tmp;
      logic [31:0] e_addr;
      logic [1:0]  e_resp;

      sz  = size_of(user);
      off = int'(addr % 8);
      if (sz == 0) err = 1'b1;
      else         err = ((addr % sz) != 0) || !last;
      e_strb = 8'(((1 << sz) - 1) << off);
      tmp    = data;
      e_data = tmp << (8 * off);
      e_addr = addr - (addr % 8);
      if (err)              begin e_we = 0;       e_resp = 2'b10; end
      else if (rd < TIMEOUT) begin e_we = rd + 1; e_resp = 2'b00; end
      else                  begin e_we = TIMEOUT; e_resp = 2'b10; end

      AWADDR = addr; WUSER = user; WDATA = data; WLAST = last;
      aw_done = 0; w_done = 0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 50) begin
         AWVALID = !aw_done && (cyc >= aw_del);
         WVALID  = !w_done && (cyc >= w_del);
         ar = AWREADY; wr = WREADY;
         if (w_done && !aw_done) check("wready_hold", {63'b0, WREADY}, 64'd0);
         if (aw_done && !w_done) check("awready_hold", {63'b0, AWREADY}, 64'd0);
         @(posedge ACLK); #1;
         if (AWVALID && ar) aw_done = 1;
         if (WVALID && wr)  w_done = 1;
         cyc++;
      end
      AWVALID = 0; WVALID = 0;
      check("handshakes", {63'b0, aw_done && w_done}, 64'd1);

      we_cnt = 0; held_bad = 0;
      while (mem_we === 1'b1 && we_cnt < 200) begin
         mem_ready = (we_cnt >= rd);
         if (we_cnt == 0) begin
            check("mem_addr", {32'b0, mem_addr}, {32'b0, e_addr});
            check("mem_wstrb", {56'b0, mem_wstrb}, {56'b0, e_strb});
            check("mem_wdata", mem_wdata, e_data);
         end
         if (mem_addr !== e_addr || mem_wstrb !== e_strb || mem_wdata !== e_data) held_bad++;
         we_cnt++;
         @(posedge ACLK); #1;
      end
      mem_ready = 0;
      check("we_cycles", 64'(we_cnt), 64'(e_we));
      if (e_we > 0) check("mem_held", 64'(held_bad), 64'd0);

      check("bvalid", {63'b0, BVALID}, 64'd1);
      check("bresp", {62'b0, BRESP}, {62'b0, e_resp});
      BREADY = 0; stall_bad = 0;
      for (int i = 0; i < bd; i++) begin
         if (stall_next) begin
            AWVALID = 1; WVALID = 1;
            AWADDR = 32'h80000010; WUSER = 4'b1000; WLAST = 1; WDATA = 64'h0123456789ABCDEF;
         end
         if (BVALID !== 1'b1 || BRESP !== e_resp || AWREADY !== 1'b0 ||
             WREADY !== 1'b0 || mem_we !== 1'b0) stall_bad++;
         @(posedge ACLK); #1;
      end
      if (bd > 0) check("stall_stable", 64'(stall_bad), 64'd0);
      BREADY = 1;
      @(posedge ACLK); #1;
      BREADY = 0; AWVALID = 0; WVALID = 0;
      check("b_done", {63'b0, BVALID}, 64'd0);
      check("awready_idle", {63'b0, AWREADY}, 64'd1);
      check("wready_idle", {63'b0, WREADY}, 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  u;
      int          r, sz, seen;

      ARESETn = 0; AWVALID = 0; WVALID = 0; BREADY = 0; mem_ready = 0;
      AWADDR = '0; WDATA = '0; WLAST = 0; WUSER = '0;
      #12;
      check("rst_awready", {63'b0, AWREADY}, 64'd0);
      check("rst_wready", {63'b0, WREADY}, 64'd0);
      check("rst_bvalid", {63'b0, BVALID}, 64'd0);
      check("rst_bresp", {62'b0, BRESP}, 64'd0);
      check("rst_mem_we", {63'b0, mem_we}, 64'd0);
      check("rst_mem_addr", {32'b0, mem_addr}, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      check("rst_mem_wstrb", {56'b0, mem_wstrb}, 64'd0);
      @(posedge ACLK); #1 ARESETn = 1;
      @(posedge ACLK); #1;

      // Directed cases
      do_txn(32'h80000004, 4'b0100, 64'h11223344, 1, 0, 0, 0, 0, 0);
      do_txn(32'h80000003, 4'b0001, 64'hAB, 1, 3, 0, 0, 0, 0);
      do_txn(32'h80000002, 4'b0100, 64'hDEADBEEF, 1, 0, 0, 0, 0, 0);
      do_txn(32'h80000002, 4'b0011, 64'hDEADBEEF, 1, 0, 0, 0, 0, 0);
      do_txn(32'h80000008, 4'b1000, 64'hCAFEF00D12345678, 0, 0, 2, 0, 0, 0);
      do_txn(32'h80000020, 4'b1000, 64'h5555AAAA5555AAAA, 1, 0, 0, 100, 0, 0);
      do_txn(32'h80000026, 4'b0010, 64'hBEEF, 1, 0, 0, TIMEOUT - 1, 0, 0);
      do_txn(32'h80000040, 4'b0100, 64'h77, 1, 0, 0, 1, 5, 1);
      do_txn(32'h80000010, 4'b1000, 64'h0123456789ABCDEF, 1, 0, 0, 0, 0, 0);

      // Reset while in MEM
      AWADDR = 32'h80000008; WUSER = 4'b1000; WDATA = 64'h1; WLAST = 1;
      AWVALID = 1; WVALID = 1;
      @(posedge ACLK); #1;
      AWVALID = 0; WVALID = 0;
      check("rstmem_we_before", {63'b0, mem_we}, 64'd1);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      ARESETn = 0;
      #1;
      check("rstmem_we", {63'b0, mem_we}, 64'd0);
      check("rstmem_bvalid", {63'b0, BVALID}, 64'd0);
      check("rstmem_wstrb", {56'b0, mem_wstrb}, 64'd0);
      @(posedge ACLK); #1 ARESETn = 1;
      @(posedge ACLK); #1;
      check("rstmem_awready", {63'b0, AWREADY}, 64'd1);
      check("rstmem_wready", {63'b0, WREADY}, 64'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (BVALID !== 1'b0 || mem_we !== 1'b0) seen++;
         @(posedge ACLK); #1;
      end
      check("rstmem_quiet", 64'(seen), 64'd0);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 11);
         if (r < 8) u = 4'(1 << (r % 4));
         else       u = 4'($urandom_range(0, 15));
         a  = $urandom;
         sz = size_of(u);
         if (sz > 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
         r = $urandom_range(0, 9);
         do_txn(a, u, {$urandom, $urandom}, ($urandom_range(0, 7) != 0),
                $urandom_range(0, 3), $urandom_range(0, 3),
                (r < 8) ? $urandom_range(0, 4) : $urandom_range(14, 20),
                $urandom_range(0, 2), $urandom_range(0, 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
